// File: rtl/menu_pkg.sv
// rtl/menu_pkg.sv - shared types and constants for the menu cursor controller
package menu_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SLIDE   = 2'd1,
        CONFIRM = 2'd2
    } menu_cursor_state_t;

    localparam int CURSOR_W = 32;
    localparam int CURSOR_H = 16;

    localparam logic [7:0] TRANSPARENT_ENCODING = 8'h11;

    // One slide step toward the target row; the step always divides the pitch.
    function automatic logic [10:0] step_toward(input logic [10:0] cur,
                                                input logic [10:0] target,
                                                input logic [10:0] step);
        if (cur < target)
            return cur + step;
        else if (cur > target)
            return cur - step;
        else
            return cur;
    endfunction

endpackage

// File: rtl/key_edge_detect.sv
// rtl/key_edge_detect.sv - registered rising-edge detector for a bundle of key levels
module key_edge_detect #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic [WIDTH-1:0] keys,
    output logic [WIDTH-1:0] rise
);

    logic [WIDTH-1:0] prev;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            prev <= '0;
            rise <= '0;
        end else begin
            prev <= keys;
            rise <= keys & ~prev;
        end
    end

endmodule

// File: rtl/menu_cursor_ctrl.sv
// rtl/menu_cursor_ctrl.sv - menu selection FSM, sliding hand cursor and bracket generation
// Optional cursor blink during CONFIRM: define MENU_CURSOR_BLINK_EN.
module menu_cursor_ctrl
    import menu_pkg::*;
#(
    parameter int NUM_OPTIONS    = 4,
    parameter int CURSOR_X       = 180,
    parameter int FIRST_Y        = 200,
    parameter int ROW_PITCH      = 40,
    parameter int SLIDE_STEP     = 4,
    parameter int CONFIRM_FRAMES = 32
) (
    input  logic                           clk,
    input  logic                           resetN,
    input  logic                           enable,
    input  logic                           startOfFrame,
    input  logic                           keyUp,
    input  logic                           keyDown,
    input  logic                           keyEnter,
    input  logic [10:0]                    pixelX,
    input  logic [10:0]                    pixelY,
    output logic [10:0]                    offsetX,
    output logic [10:0]                    offsetY,
    output logic                           InsideRectangle,
    output logic [$clog2(NUM_OPTIONS)-1:0] selIndex,
    output logic                           selectValid
);

    localparam int SEL_W = $clog2(NUM_OPTIONS);
    localparam int FC_RAW = $clog2(CONFIRM_FRAMES + 1);
    localparam int FC_W = (FC_RAW < 3) ? 3 : FC_RAW;

    localparam logic [10:0] X0    = 11'(CURSOR_X);
    localparam logic [10:0] Y0    = 11'(FIRST_Y);
    localparam logic [10:0] PITCH = 11'(ROW_PITCH);
    localparam logic [10:0] STEP  = 11'(SLIDE_STEP);
    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_OPTIONS - 1);
    localparam logic [FC_W-1:0]  FC_LAST  = FC_W'(CONFIRM_FRAMES - 1);

    menu_cursor_state_t state, state_nx;
    logic [SEL_W-1:0] sel_nx;
    logic [10:0]      cur_y, cur_y_nx;
    logic [10:0]      target_y;
    logic [FC_W-1:0]  frame_cnt, frame_cnt_nx;
    logic             select_valid_nx;

    logic [2:0] key_rise;
    logic       up_edge, down_edge, enter_edge;

    key_edge_detect #(.WIDTH(3)) u_key_edge (
        .clk    (clk),
        .resetN (resetN),
        .keys   ({keyEnter, keyDown, keyUp}),
        .rise   (key_rise)
    );

    assign up_edge    = key_rise[0];
    assign down_edge  = key_rise[1];
    assign enter_edge = key_rise[2];

    assign target_y = Y0 + 11'(selIndex) * PITCH;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state       <= IDLE;
            selIndex    <= '0;
            cur_y       <= Y0;
            frame_cnt   <= '0;
            selectValid <= 1'b0;
        end else begin
            state       <= state_nx;
            selIndex    <= sel_nx;
            cur_y       <= cur_y_nx;
            frame_cnt   <= frame_cnt_nx;
            selectValid <= select_valid_nx;
        end
    end

    always_comb begin
        state_nx        = state;
        sel_nx          = selIndex;
        cur_y_nx        = cur_y;
        frame_cnt_nx    = frame_cnt;
        select_valid_nx = 1'b0;

        if (!enable) begin
            state_nx = IDLE;
            cur_y_nx = target_y;
        end else begin
            case (state)
                IDLE: begin
                    if (enter_edge) begin
                        select_valid_nx = 1'b1;
                        frame_cnt_nx    = '0;
                        state_nx        = CONFIRM;
                    end else if (up_edge ^ down_edge) begin
                        if (down_edge)
                            sel_nx = (selIndex == LAST_SEL) ? '0 : selIndex + 1'b1;
                        else
                            sel_nx = (selIndex == '0) ? LAST_SEL : selIndex - 1'b1;
                        state_nx = SLIDE;
                    end
                end
                SLIDE: begin
                    if (cur_y == target_y)
                        state_nx = IDLE;
                    else if (startOfFrame)
                        cur_y_nx = step_toward(cur_y, target_y, STEP);
                end
                CONFIRM: begin
                    if (startOfFrame) begin
                        if (frame_cnt == FC_LAST) begin
                            frame_cnt_nx = '0;
                            state_nx     = IDLE;
                        end else begin
                            frame_cnt_nx = frame_cnt + 1'b1;
                        end
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    // 12-bit compares keep the right/bottom bounds from wrapping near the screen edge.
    logic hit_x, hit_y, show;

    assign hit_x = ({1'b0, pixelX} >= {1'b0, X0}) &&
                   ({1'b0, pixelX} <  ({1'b0, X0} + 12'(CURSOR_W)));
    assign hit_y = ({1'b0, pixelY} >= {1'b0, cur_y}) &&
                   ({1'b0, pixelY} <  ({1'b0, cur_y} + 12'(CURSOR_H)));

`ifdef MENU_CURSOR_BLINK_EN
    assign show = enable && hit_x && hit_y && !((state == CONFIRM) && frame_cnt[2]);
`else
    assign show = enable && hit_x && hit_y;
`endif

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            InsideRectangle <= 1'b0;
            offsetX         <= '0;
            offsetY         <= '0;
        end else begin
            InsideRectangle <= show;
            offsetX         <= show ? (pixelX - X0)    : 11'd0;
            offsetY         <= show ? (pixelY - cur_y) : 11'd0;
        end
    end

endmodule

// File: tb/tb_menu_cursor_ctrl.sv
// tb/tb_menu_cursor_ctrl.sv - scoreboard bench for menu_cursor_ctrl (honours MENU_CURSOR_BLINK_EN)
module tb_menu_cursor_ctrl;

    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic        enable = 1'b1;
    logic        startOfFrame = 1'b0;
    logic        keyUp = 1'b0, keyDown = 1'b0, keyEnter = 1'b0;
    logic [10:0] pixelX = '0, pixelY = '0;
    logic [10:0] offsetX, offsetY;
    logic        InsideRectangle;
    logic [1:0]  selIndex;
    logic        selectValid;

    menu_cursor_ctrl dut (
        .clk             (clk),
        .resetN          (resetN),
        .enable          (enable),
        .startOfFrame    (startOfFrame),
        .keyUp           (keyUp),
        .keyDown         (keyDown),
        .keyEnter        (keyEnter),
        .pixelX          (pixelX),
        .pixelY          (pixelY),
        .offsetX         (offsetX),
        .offsetY         (offsetY),
        .InsideRectangle (InsideRectangle),
        .selIndex        (selIndex),
        .selectValid     (selectValid)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       ins;
        logic [10:0] ox;
        logic [10:0] oy;
    } bexp_t;

    bexp_t      bq[$];
    logic [1:0] sv_q[$];
    int checks = 0;
    int errors = 0;
    logic probe_now = 1'b0;
    logic probe_d = 1'b0;
    logic sv_prev = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        probe_d = probe_now;
    end

    // Bracket monitor pops one expectation per probed pixel; pulse monitor pops per selectValid.
    initial forever begin
        @(negedge clk);
        if (probe_d) begin
            if (bq.size() == 0) begin
                chk("bracket_unexpected_probe", 1, 0);
            end else begin
                bexp_t e;
                e = bq.pop_front();
                chk({e.name, "_inside"}, int'(InsideRectangle), int'(e.ins));
                chk({e.name, "_offx"}, int'(offsetX), int'(e.ox));
                chk({e.name, "_offy"}, int'(offsetY), int'(e.oy));
            end
        end
        if (resetN && selectValid) begin
            if (sv_prev)
                chk("select_valid_width", 2, 1);
            else if (sv_q.size() == 0)
                chk("select_valid_unexpected", 1, 0);
            else
                chk("select_valid_sel", int'(selIndex), int'(sv_q.pop_front()));
        end
        sv_prev = selectValid;
    end

    task automatic probe(input int x, input int y, input logic ins,
                         input int ox, input int oy, input string nm);
        bexp_t e;
        @(posedge clk); #1;
        pixelX = 11'(x);
        pixelY = 11'(y);
        probe_now = 1'b1;
        e.name = nm; e.ins = ins; e.ox = 11'(ox); e.oy = 11'(oy);
        bq.push_back(e);
        @(posedge clk); #1;
        probe_now = 1'b0;
    endtask

    task automatic check_cury(input int y, input string nm);
        probe(185, y, 1'b1, 5, 0, {nm, "_top"});
        probe(185, y - 1, 1'b0, 0, 0, {nm, "_above"});
    endtask

    task automatic frames(input int n);
        repeat (n) begin
            @(posedge clk); #1 startOfFrame = 1'b1;
            @(posedge clk); #1 startOfFrame = 1'b0;
        end
    endtask

    // k: 0 up, 1 down, 2 enter, 3 up+down together
    task automatic press(input int k, input int exp_sel, input string nm);
        @(posedge clk); #1;
        keyUp    = (k == 0 || k == 3);
        keyDown  = (k == 1 || k == 3);
        keyEnter = (k == 2);
        @(posedge clk); #1;
        keyUp = 1'b0; keyDown = 1'b0; keyEnter = 1'b0;
        @(posedge clk); #1;
        chk(nm, int'(selIndex), exp_sel);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_inside", int'(InsideRectangle), 0);
        chk("rst_offx", int'(offsetX), 0);
        chk("rst_offy", int'(offsetY), 0);
        chk("rst_sel", int'(selIndex), 0);
        chk("rst_valid", int'(selectValid), 0);
        @(posedge clk); #1 resetN = 1'b1;

        probe(180, 200, 1'b1, 0, 0, "px_180_200");
        probe(212, 200, 1'b0, 0, 0, "px_212_200");
        probe(211, 215, 1'b1, 31, 15, "px_211_215");
        probe(180, 216, 1'b0, 0, 0, "px_180_216");

        press(1, 1, "down_sel1");
        frames(1);
        check_cury(204, "slide_204");
        frames(9);
        check_cury(240, "slide_240");

        press(0, 0, "up_sel0");
        frames(10);
        check_cury(200, "back_200");

        press(0, 3, "wrap_up_sel3");
        frames(15);
        check_cury(260, "wrap_mid_260");
        press(1, 3, "slide_ignores_down");
        press(0, 3, "slide_ignores_up");
        frames(15);
        check_cury(320, "wrap_end_320");

        press(3, 3, "up_down_same_cycle");

        @(posedge clk); #1 keyDown = 1'b1;
        repeat (100) @(posedge clk);
        #1 keyDown = 1'b0;
        @(posedge clk); #1;
        chk("hold_down_one_step", int'(selIndex), 0);
        frames(30);
        check_cury(200, "wrap_down_200");

        press(1, 1, "down_to_1");
        frames(10);
        press(1, 2, "down_to_2");
        frames(10);
        check_cury(280, "row2_280");

        sv_q.push_back(2'd2);
        press(2, 2, "enter_sel2");
        frames(4);
`ifdef MENU_CURSOR_BLINK_EN
        probe(185, 280, 1'b0, 0, 0, "confirm_frame4_blink");
`else
        probe(185, 280, 1'b1, 5, 0, "confirm_frame4_steady");
`endif
        frames(27);
        press(1, 2, "confirm_ignores_down");
        frames(1);
        press(1, 3, "after_confirm_down");
        frames(3);
        check_cury(292, "mid_slide_292");

        @(posedge clk); #1 enable = 1'b0;
        probe(185, 292, 1'b0, 0, 0, "disabled_292");
        probe(185, 320, 1'b0, 0, 0, "disabled_320");
        press(2, 3, "disabled_enter");
        @(posedge clk); #1 keyDown = 1'b1;
        repeat (3) @(posedge clk);
        #1 enable = 1'b1;
        repeat (3) @(posedge clk);
        #1 keyDown = 1'b0;
        @(posedge clk); #1;
        chk("held_key_on_enable", int'(selIndex), 3);
        check_cury(320, "snapped_320");

        repeat (4) @(posedge clk);
        chk("bracket_queue_drained", bq.size(), 0);
        chk("select_queue_drained", sv_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/menu_cursor_ctrl.md
# menu_cursor_ctrl

Menu selection controller that drives the 32x16 hand-cursor bitmap on the game menu screens. It debounces-by-edge the menu keys, keeps the selected option index, and slides the cursor vertically between option rows one step per video frame. Each pixel it emits the bracket signals (`InsideRectangle`, `offsetX`, `offsetY`) that the cursor bitmap stage consumes directly. It also reports the confirmed selection to the game state logic.

## Interface
Parameters:
- `NUM_OPTIONS`, 4: number of menu rows; must be ≥2.
- `CURSOR_X`, 180: fixed left pixel column of the cursor.
- `FIRST_Y`, 200: top pixel row of option 0.
- `ROW_PITCH`, 40: vertical distance between option rows, in pixels.
- `SLIDE_STEP`, 4: pixels moved per frame while sliding; must divide `ROW_PITCH`.
- `CONFIRM_FRAMES`, 32: frames spent in CONFIRM after a selection.

Ports:
- `clk`  in  1: pixel clock.
- `resetN`  in  1: reset, asynchronous, active-low. Reset is resetN, asynchronous, active-low; clock is clk.
- `enable`  in  1: menu screen active.
- `startOfFrame`  in  1: one-cycle pulse per frame.
- `keyUp`, `keyDown`, `keyEnter`  in  1 each: synchronized key levels.
- `pixelX`, `pixelY`  in  11 each: current scan coordinates.
- `offsetX`, `offsetY`  out  11 each: pixel offset from the cursor's top-left corner.
- `InsideRectangle`  out  1: current pixel is inside the cursor bracket.
- `selIndex`  out  $clog2(NUM_OPTIONS): selected option.
- `selectValid`  out  1: one-cycle pulse when a selection is confirmed.

## Operation
- Each key has a previous-value register; edge = `key & ~prev`. Only edges act; held keys never repeat.
- State machine, three states:
  - IDLE:
    - Down edge: `selIndex` ← (`selIndex`+1) mod N; go to SLIDE.
    - Up edge: `selIndex` ← `selIndex`−1, with 0 wrapping to N−1; go to SLIDE.
    - Up and down edges in the same cycle: both ignored.
    - Enter edge: pulse `selectValid`, clear the frame counter, go to CONFIRM. Enter takes priority over up/down in the same cycle.
  - SLIDE:
    - `targetY` = `FIRST_Y` + `selIndex`·`ROW_PITCH`.
    - On each `startOfFrame`, `curY` moves `SLIDE_STEP` toward `targetY`. When `curY` equals `targetY`, go to IDLE.
    - All key edges are ignored.
    - A wrap (for example 3→0) slides the full distance; it does not jump.
  - CONFIRM:
    - Count `startOfFrame` pulses. After `CONFIRM_FRAMES` pulses, go to IDLE.
    - Key edges are ignored.
- `enable` low:
  - Synchronously forces IDLE and sets `curY` to `targetY`.
  - `InsideRectangle` is forced to 0.
  - `selIndex` is retained.
  - `selectValid` never pulses.
  - Edge registers keep tracking the keys, so a key held while `enable` rises does not fire.
- Bracket generation:
  - `InsideRectangle` = (`CURSOR_X` ≤ `pixelX` < `CURSOR_X`+32) and (`curY` ≤ `pixelY` < `curY`+16).
  - `offsetX` = `pixelX`−`CURSOR_X` and `offsetY` = `pixelY`−`curY`, both 11-bit unsigned.
  - Offsets are 0 when the pixel is outside the bracket.
- Internal arithmetic is 11-bit. `curY` never leaves [`FIRST_Y`, `FIRST_Y`+(N−1)·`ROW_PITCH`].

## Timing
- Reset values: `offsetX`=0, `offsetY`=0, `InsideRectangle`=0, `selIndex`=0, `selectValid`=0. Internally: state IDLE, `curY`=`FIRST_Y`, frame counter 0, edge registers 0.
- Bracket outputs are registered: one-cycle latency from `pixelX`/`pixelY`. The bitmap stage adds its own cycle.
- If a key is first sampled high at edge t:
  - The state and `selIndex` change at edge t+1.
  - `selectValid` is high for exactly the cycle after edge t+1.
- `curY` changes only on cycles where `startOfFrame` is high. Slide duration is `ROW_PITCH`/`SLIDE_STEP` frames per row (default 10).
- Reset asserted mid-slide or mid-confirm returns to reset values immediately.

## Configuration
- Macro: `MENU_CURSOR_BLINK_EN`.
- Defined: during CONFIRM, `InsideRectangle` is forced to 0 whenever bit 2 of the frame counter is 1. This blinks the cursor every 4 frames.
- Undefined: the cursor stays steady in CONFIRM, and the blink logic is absent.

## Structure
- Package `menu_pkg`:
  - state enum `menu_cursor_state_t` (IDLE, SLIDE, CONFIRM);
  - `CURSOR_W`=32 and `CURSOR_H`=16;
  - `TRANSPARENT_ENCODING`=8'h11, shared with the bitmap stages.
- Sub-module `key_edge_detect`: parameterized width, with registered previous value and a rising-edge pulse output. It is instantiated once for the three keys.

## Test plan
- Reset, then scan pixel (180,200): `InsideRectangle`=1 and offsets (0,0) one cycle later. Pixel (212,200) gives `InsideRectangle`=0 and offsets 0.
- Pulse `keyDown` once: `selIndex` becomes 1 the next cycle. `curY` reaches 240 after exactly 10 `startOfFrame` pulses, stepping 204, 208, …
- With `selIndex`=0, pulse `keyUp`: `selIndex`=3, and `curY` slides to 320 over 30 frames. Key edges during the slide are ignored.
- Raise `keyUp` and `keyDown` in the same cycle: no change. Hold `keyDown` for 100 cycles: exactly one step.
- In IDLE with `selIndex`=2, pulse `keyEnter`: one-cycle `selectValid` with `selIndex`=2. The block returns to IDLE after 32 frames. With the blink macro, `InsideRectangle` is 0 in frames 4–7 of CONFIRM.
- Drop `enable` mid-slide: `InsideRectangle`=0 and `curY` snaps to target. With the key still held when `enable` rises, no edge fires.
